// File: rtl/spu_pkg.sv
// spu_pkg: shared sizes, types and FSM states for the SPU register file.
//  NUM_REGS / DATA_W / ADDR_W : array geometry
//  quad_t  : one 128-bit register, bit 0 is the MSB of the preferred slot
//  raddr_t : register address
//  rf_state_t : scrub/run state of the register file
package spu_pkg;

    localparam int unsigned NUM_REGS = 128;
    localparam int unsigned DATA_W   = 128;
    localparam int unsigned ADDR_W   = 7;

    typedef logic [0:DATA_W-1] quad_t;
    typedef logic [0:ADDR_W-1] raddr_t;

    typedef enum logic {
        RF_SCRUB = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/spu_rf_fwd_mux.sv
// spu_rf_fwd_mux: per-read-port bypass select between array data and the two
// same-cycle writeback ports. Writeback port 0 has priority over port 1.
//  rd_addr     in  read address of this port
//  arr_data    in  array contents at rd_addr
//  wr0_*       in  writeback port 0 (stage 6) enable/address/data
//  wr1_*       in  writeback port 1 (stage 7) enable/address/data
//  rd_data_c   out combinational selected read data
module spu_rf_fwd_mux
    import spu_pkg::*;
(
    input  logic [0:ADDR_W-1] rd_addr,
    input  logic [0:DATA_W-1] arr_data,
    input  logic              wr0_en,
    input  logic [0:ADDR_W-1] wr0_addr,
    input  logic [0:DATA_W-1] wr0_data,
    input  logic              wr1_en,
    input  logic [0:ADDR_W-1] wr1_addr,
    input  logic [0:DATA_W-1] wr1_data,
    output logic [0:DATA_W-1] rd_data_c
);

    // Port 0 is checked last so it overrides port 1 on a collision.
    always_comb begin
        rd_data_c = arr_data;
        if (wr1_en && (wr1_addr == rd_addr)) begin
            rd_data_c = wr1_data;
        end
        if (wr0_en && (wr0_addr == rd_addr)) begin
            rd_data_c = wr0_data;
        end
    end

endmodule

// File: rtl/spu_reg_file.sv
// spu_reg_file: 128x128-bit SPU register file, two writeback ports, three
// registered read ports, and a post-reset scrub that zeroes every entry.
//  clk, reset                synchronous active-high reset
//  ra/rb/rc_addr  in         read addresses; ra/rb/rc out one cycle later
//  rt_wb, rt_addr_wb, reg_write_wb     writeback port 0 (stage 6)
//  rt_int, rt_addr_int, reg_write_int  writeback port 1 (stage 7)
//  rf_busy        out        high while the scrub runs; accesses ignored
// Optional feature macro RF_BYPASS_EN: same-cycle write data is forwarded to
// a read of the same address. Without it the read returns the old value.
module spu_reg_file
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [0:ADDR_W-1] ra_addr,
    input  logic [0:ADDR_W-1] rb_addr,
    input  logic [0:ADDR_W-1] rc_addr,
    output logic [0:DATA_W-1] ra,
    output logic [0:DATA_W-1] rb,
    output logic [0:DATA_W-1] rc,
    input  logic [0:DATA_W-1] rt_wb,
    input  logic [0:ADDR_W-1] rt_addr_wb,
    input  logic              reg_write_wb,
    input  logic [0:DATA_W-1] rt_int,
    input  logic [0:ADDR_W-1] rt_addr_int,
    input  logic              reg_write_int,
    output logic              rf_busy
);

    quad_t     mem [NUM_REGS];

    rf_state_t state_q, state_d;
    raddr_t    cnt_q, cnt_d;
    logic      busy_q, busy_d;
    quad_t     ra_q, ra_d;
    quad_t     rb_q, rb_d;
    quad_t     rc_q, rc_d;

    logic      wr0_en_c, wr1_en_c, scrub_en_c;
    quad_t     ra_rd_c, rb_rd_c, rc_rd_c;

    // Write-port qualification: only honoured in RUN.
    always_comb begin
        wr0_en_c   = 1'b0;
        wr1_en_c   = 1'b0;
        scrub_en_c = 1'b0;
        if (state_q == RF_RUN) begin
            wr0_en_c = reg_write_wb;
            wr1_en_c = reg_write_int;
        end else begin
            scrub_en_c = 1'b1;
        end
    end

    // Read data path, optionally with same-cycle write forwarding.
`ifdef RF_BYPASS_EN
    spu_rf_fwd_mux u_fwd_ra (
        .rd_addr   (ra_addr),
        .arr_data  (mem[ra_addr]),
        .wr0_en    (wr0_en_c),
        .wr0_addr  (rt_addr_wb),
        .wr0_data  (rt_wb),
        .wr1_en    (wr1_en_c),
        .wr1_addr  (rt_addr_int),
        .wr1_data  (rt_int),
        .rd_data_c (ra_rd_c)
    );
    spu_rf_fwd_mux u_fwd_rb (
        .rd_addr   (rb_addr),
        .arr_data  (mem[rb_addr]),
        .wr0_en    (wr0_en_c),
        .wr0_addr  (rt_addr_wb),
        .wr0_data  (rt_wb),
        .wr1_en    (wr1_en_c),
        .wr1_addr  (rt_addr_int),
        .wr1_data  (rt_int),
        .rd_data_c (rb_rd_c)
    );
    spu_rf_fwd_mux u_fwd_rc (
        .rd_addr   (rc_addr),
        .arr_data  (mem[rc_addr]),
        .wr0_en    (wr0_en_c),
        .wr0_addr  (rt_addr_wb),
        .wr0_data  (rt_wb),
        .wr1_en    (wr1_en_c),
        .wr1_addr  (rt_addr_int),
        .wr1_data  (rt_int),
        .rd_data_c (rc_rd_c)
    );
`else
    always_comb begin
        ra_rd_c = mem[ra_addr];
        rb_rd_c = mem[rb_addr];
        rc_rd_c = mem[rc_addr];
    end
`endif

    // Next-state: scrub walks every address once, then RUN until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ra_d    = '0;
        rb_d    = '0;
        rc_d    = '0;
        case (state_q)
            RF_SCRUB: begin
                cnt_d  = cnt_q + ADDR_W'(1);
                busy_d = 1'b1;
                if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = RF_RUN;
                    busy_d  = 1'b0;
                end
            end
            RF_RUN: begin
                busy_d = 1'b0;
                ra_d   = ra_rd_c;
                rb_d   = rb_rd_c;
                rc_d   = rc_rd_c;
            end
            default: begin
                state_d = RF_SCRUB;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RF_SCRUB;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
        end
    end

    // Array storage, no reset; port 0 written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (scrub_en_c) begin
                mem[cnt_q] <= '0;
            end else begin
                if (wr1_en_c) begin
                    mem[rt_addr_int] <= rt_int;
                end
                if (wr0_en_c) begin
                    mem[rt_addr_wb] <= rt_wb;
                end
            end
        end
    end

    assign ra      = ra_q;
    assign rb      = rb_q;
    assign rc      = rc_q;
    assign rf_busy = busy_q;

endmodule

// File: tb/tb_spu_reg_file.sv
// tb_spu_reg_file: directed self-checking bench for spu_reg_file.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_spu_reg_file;

    logic         clk = 1'b0;
    logic         reset;
    logic [0:6]   ra_addr, rb_addr, rc_addr;
    logic [0:127] ra, rb, rc;
    logic [0:127] rt_wb, rt_int;
    logic [0:6]   rt_addr_wb, rt_addr_int;
    logic         reg_write_wb, reg_write_int;
    logic         rf_busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] V3    = 128'h4228000040647ae1bfc00000bb83126f;
    localparam logic [127:0] V9    = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] V11   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] V12A  = 128'hAAAA0000_5555FFFF_AAAA0000_5555FFFF;
    localparam logic [127:0] V12B  = 128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F;

    spu_reg_file dut (
        .clk           (clk),
        .reset         (reset),
        .ra_addr       (ra_addr),
        .rb_addr       (rb_addr),
        .rc_addr       (rc_addr),
        .ra            (ra),
        .rb            (rb),
        .rc            (rc),
        .rt_wb         (rt_wb),
        .rt_addr_wb    (rt_addr_wb),
        .reg_write_wb  (reg_write_wb),
        .rt_int        (rt_int),
        .rt_addr_int   (rt_addr_int),
        .reg_write_int (reg_write_int),
        .rf_busy       (rf_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts falling-edge samples with rf_busy high; flags any nonzero read data.
    task automatic scrub_count(output int n, output logic nz);
        n  = 0;
        nz = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!rf_busy) break;
            n++;
            if ((ra | rb | rc) != '0) nz = 1'b1;
            @(negedge clk);
        end
    endtask

    // Reads every register through ra and expects zero.
    task automatic read_all_zero(input string tag);
        for (int i = 0; i <= 128; i++) begin
            if (i > 0) check($sformatf("%s_r%0d", tag, i - 1), ra, 128'h0);
            if (i < 128) ra_addr = 7'(i);
            @(negedge clk);
        end
    endtask

    logic bypass;
    int   nbusy;
    logic nz;

    initial begin
`ifdef RF_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        reset = 1'b1;
        ra_addr = '0; rb_addr = '0; rc_addr = '0;
        rt_wb = '0; rt_int = '0; rt_addr_wb = '0; rt_addr_int = '0;
        reg_write_wb = 1'b0; reg_write_int = 1'b0;

        // 1: reset two cycles, scrub with ignored writes to r5
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 128'(rf_busy), 128'h1);
        check("rst_ra", ra, 128'h0);
        check("rst_rb", rb, 128'h0);
        check("rst_rc", rc, 128'h0);
        reset = 1'b0;
        rt_wb = '1; rt_addr_wb = 7'd5; reg_write_wb = 1'b1;
        rt_int = '1; rt_addr_int = 7'd5; reg_write_int = 1'b1;
        scrub_count(nbusy, nz);
        reg_write_wb = 1'b0; reg_write_int = 1'b0;
        check("scrub1_cycles", 128'(nbusy), 128'd128);
        check("scrub1_rd_zero", 128'(nz), 128'h0);
        check("scrub1_busy_low", 128'(rf_busy), 128'h0);
        read_all_zero("scrub1");

        // 2: write r3 via port 0, read back on ra
        rt_wb = V3; rt_addr_wb = 7'd3; reg_write_wb = 1'b1;
        @(negedge clk);
        reg_write_wb = 1'b0; ra_addr = 7'd3;
        @(negedge clk);
        check("wr_rd_r3", ra, V3);

        // 3: collision on r7, port 0 wins
        rt_wb = 128'h1; rt_addr_wb = 7'd7; reg_write_wb = 1'b1;
        rt_int = 128'h2; rt_addr_int = 7'd7; reg_write_int = 1'b1;
        @(negedge clk);
        reg_write_wb = 1'b0; reg_write_int = 1'b0; rb_addr = 7'd7;
        @(negedge clk);
        check("collide_r7", rb, 128'h1);

        // 4: same-cycle write/read of r9 on rc
        rt_wb = V9; rt_addr_wb = 7'd9; reg_write_wb = 1'b1; rc_addr = 7'd9;
        @(negedge clk);
        reg_write_wb = 1'b0;
        check("bypass_r9", rc, bypass ? V9 : 128'h0);
        @(negedge clk);
        check("late_r9", rc, V9);

        // 4b: same-cycle via port 1 only on ra
        rt_int = V11; rt_addr_int = 7'd11; reg_write_int = 1'b1; ra_addr = 7'd11;
        @(negedge clk);
        reg_write_int = 1'b0;
        check("bypass_p1_r11", ra, bypass ? V11 : 128'h0);
        @(negedge clk);
        check("late_r11", ra, V11);

        // 4c: same-cycle collision on r12 read by rb
        rt_wb = V12A; rt_addr_wb = 7'd12; reg_write_wb = 1'b1;
        rt_int = V12B; rt_addr_int = 7'd12; reg_write_int = 1'b1; rb_addr = 7'd12;
        @(negedge clk);
        reg_write_wb = 1'b0; reg_write_int = 1'b0;
        check("bypass_coll_r12", rb, bypass ? V12A : 128'h0);
        @(negedge clk);
        check("late_r12", rb, V12A);

        // 5: three-port alias, then distinct addresses
        ra_addr = 7'd3; rb_addr = 7'd3; rc_addr = 7'd3;
        @(negedge clk);
        check("alias_ra", ra, V3);
        check("alias_rb", rb, V3);
        check("alias_rc", rc, V3);
        ra_addr = 7'd3; rb_addr = 7'd7; rc_addr = 7'd9;
        @(negedge clk);
        check("dist_ra_r3", ra, V3);
        check("dist_rb_r7", rb, 128'h1);
        check("dist_rc_r9", rc, V9);

        // 6: one-cycle reset pulse mid-run
        reset = 1'b1;
        @(negedge clk);
        check("rst2_ra", ra, 128'h0);
        check("rst2_rb", rb, 128'h0);
        check("rst2_rc", rc, 128'h0);
        check("rst2_busy", 128'(rf_busy), 128'h1);
        reset = 1'b0;
        scrub_count(nbusy, nz);
        check("scrub2_cycles", 128'(nbusy), 128'd128);
        check("scrub2_rd_zero", 128'(nz), 128'h0);
        check("scrub2_busy_low", 128'(rf_busy), 128'h0);
        read_all_zero("scrub2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
